// File: rtl/uvmt_mio_cli_st_rst_seq.sv
// ---------------------------------------------------------------------------
// uvmt_mio_cli_st_rst_seq
//
// Reset synchroniser and staged-release sequencer. The raw generator reset
// is synchronised to clk, held for HOLD_CYCLES, then the active-low outputs
// are released one at a time, STAGGER_CYCLES apart, bit 0 first. A soft
// request replays the hold/release sequence without touching reset_n.
//
// Optional feature macro: UVMT_MIO_CLI_ST_RST_SEQ_SW_REQ_EN
//   defined   : sw_reset_req restarts the sequence from HOLD.
//   undefined : sw_reset_req is ignored and the sequence runs only after reset_n.
//
// Ports
//   clk          in   bench clock
//   reset_n      in   raw reset, asynchronous, active-low
//   sw_reset_req in   synchronous soft-reset request
//   rst_n_out    out  [NUM_OUTS] staged active-low resets, bit 0 first
//   all_ready    out  registered, high once every rst_n_out bit is 1
//   busy         out  high in any state other than DONE
//   rst_cnt      out  [8] completed release sequences, saturating at 255
// ---------------------------------------------------------------------------
module uvmt_mio_cli_st_rst_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int NUM_OUTS       = 4,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sw_reset_req,
  output logic [NUM_OUTS-1:0] rst_n_out,
  output logic                all_ready,
  output logic                busy,
  output logic [7:0]          rst_cnt
);

  localparam int HW = (HOLD_CYCLES    > 1) ? $clog2(HOLD_CYCLES)    : 1;
  localparam int SW = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam int IW = (NUM_OUTS       > 1) ? $clog2(NUM_OUTS)       : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUTS - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Synchroniser: ones shift in from stage 0; reset clears the whole chain.
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   sync_rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_pipe <= '0;
    else          sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_rst_n = sync_pipe[SYNC_STAGES-1];

  // Soft request, gated by the build option.
  logic sw_req;
`ifdef UVMT_MIO_CLI_ST_RST_SEQ_SW_REQ_EN
  assign sw_req = sw_reset_req;
`else
  logic sw_req_unused;
  assign sw_req_unused = sw_reset_req;
  assign sw_req        = 1'b0;
`endif

  state_t                state, state_nxt;
  logic [HW-1:0]         hold_cnt, hold_nxt;
  logic [SW-1:0]         stag_cnt, stag_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [NUM_OUTS-1:0]   out_nxt;
  logic                  rdy_nxt;
  logic [7:0]            cnt_nxt, cnt_inc;

  assign cnt_inc = (rst_cnt == 8'hFF) ? rst_cnt : rst_cnt + 8'd1;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    stag_nxt  = stag_cnt;
    idx_nxt   = idx;
    out_nxt   = rst_n_out;
    rdy_nxt   = all_ready;
    cnt_nxt   = rst_cnt;

    case (state)
      ST_ASSERT: begin
        out_nxt = '0;
        rdy_nxt = 1'b0;
        if (sync_rst_n) begin
          state_nxt = ST_HOLD;
          hold_nxt  = '0;
        end
      end
      ST_HOLD: begin
        hold_nxt = hold_cnt + HW'(1);
        if (hold_cnt == HOLD_LAST) begin
          out_nxt[0] = 1'b1;
          stag_nxt   = '0;
          idx_nxt    = IW'(1);
          if (NUM_OUTS == 1) begin
            state_nxt = ST_DONE;
            rdy_nxt   = 1'b1;
            cnt_nxt   = cnt_inc;
          end else begin
            state_nxt = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        stag_nxt = stag_cnt + SW'(1);
        if (stag_cnt == STAG_LAST) begin
          out_nxt[idx] = 1'b1;
          stag_nxt     = '0;
          idx_nxt      = idx + IW'(1);
          if (idx == IDX_LAST) begin
            state_nxt = ST_DONE;
            rdy_nxt   = 1'b1;
            cnt_nxt   = cnt_inc;
          end
        end
      end
      ST_DONE: begin
      end
      default: state_nxt = ST_ASSERT;
    endcase

    // A soft request overrides any release or completion on the same edge,
    // so an aborted sequence never reaches the counter.
    if (sw_req && state != ST_ASSERT) begin
      state_nxt = ST_HOLD;
      hold_nxt  = '0;
      out_nxt   = '0;
      rdy_nxt   = 1'b0;
      cnt_nxt   = rst_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_ASSERT;
      hold_cnt  <= '0;
      stag_cnt  <= '0;
      idx       <= '0;
      rst_n_out <= '0;
      all_ready <= 1'b0;
      rst_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      stag_cnt  <= stag_nxt;
      idx       <= idx_nxt;
      rst_n_out <= out_nxt;
      all_ready <= rdy_nxt;
      rst_cnt   <= cnt_nxt;
    end
  end

  assign busy = (state != ST_DONE);

endmodule

// File: tb/tb_uvmt_mio_cli_st_rst_seq.sv
// ---------------------------------------------------------------------------
// Bench for uvmt_mio_cli_st_rst_seq. The reference model tracks only the edge
// at which bit 0 of the current sequence releases (r0) and the completed
// sequence count; every output is derived from those by arithmetic.
// ---------------------------------------------------------------------------
module tb_uvmt_mio_cli_st_rst_seq;

  localparam int SYNC  = 2;
  localparam int HOLD  = 16;
  localparam int N     = 4;
  localparam int S     = 4;
  localparam int NEVER = 1 << 30;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         sw_reset_req;
  logic [N-1:0] rst_n_out;
  logic         all_ready;
  logic         busy;
  logic [7:0]   rst_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state
  int cyc   = 0;
  int r0    = NEVER;
  int m_cnt = 0;

  uvmt_mio_cli_st_rst_seq #(
    .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .NUM_OUTS(N), .STAGGER_CYCLES(S)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw_reset_req(sw_reset_req),
    .rst_n_out(rst_n_out), .all_ready(all_ready), .busy(busy), .rst_cnt(rst_cnt)
  );

  always #5 clk = ~clk;

  // {rst_n_out, all_ready, busy, rst_cnt} expected after edge cyc
  function automatic logic [N+9:0] exp_vec();
    logic [N-1:0] o;
    logic         rdy;
    for (int i = 0; i < N; i++) o[i] = (r0 != NEVER) && (cyc >= r0 + i*S);
    rdy = (r0 != NEVER) && (cyc >= r0 + (N-1)*S);
    return {o, rdy, !rdy, m_cnt[7:0]};
  endfunction

  // One clock edge with the given soft request; updates the model.
  task automatic tick(input bit req);
    bit took;
    took = 0;
    sw_reset_req = req;
    @(posedge clk);
    cyc++;
`ifdef UVMT_MIO_CLI_ST_RST_SEQ_SW_REQ_EN
    // Honoured only once HOLD has been entered (edge r0-HOLD).
    if (req && r0 != NEVER && cyc > r0 - HOLD) begin
      r0   = cyc + HOLD;
      took = 1;
    end
`endif
    if (!took && r0 != NEVER && cyc == r0 + (N-1)*S)
      m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    @(negedge clk);
    sw_reset_req = 1'b0;
  endtask

  // Pulse reset_n low across one posedge, starting just after a negedge.
  task automatic apply_reset(input bit renum);
    @(negedge clk);
    reset_n = 1'b0;
    r0    = NEVER;
    m_cnt = 0;
    #1;
    n_chk++;
    if ({rst_n_out, all_ready, busy, rst_cnt} !== {{N{1'b0}}, 1'b0, 1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL async_clear got=%h exp=%h", {rst_n_out, all_ready, busy, rst_cnt},
               {{N{1'b0}}, 1'b0, 1'b1, 8'd0});
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset_n = 1'b1;
    if (renum) cyc = 0;
    r0 = cyc + SYNC + 1 + HOLD;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({rst_n_out, all_ready, busy, rst_cnt} !== {{N{1'b0}}, 1'b0, 1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", {rst_n_out, all_ready, busy, rst_cnt},
               {{N{1'b0}}, 1'b0, 1'b1, 8'd0});
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_power_on();
    int           marks [5];
    logic [N-1:0] vals  [5];
    marks = '{18, 19, 23, 27, 31};
    vals  = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
    apply_reset(1);
    for (int k = 0; k < 5; k++) begin
      while (cyc < marks[k]) begin
        tick(0);
        n_chk++;
        if ({rst_n_out, all_ready, busy, rst_cnt} !== exp_vec()) begin
          n_fail++;
          $display("FAIL power_on cyc=%0d got=%h exp=%h", cyc,
                   {rst_n_out, all_ready, busy, rst_cnt}, exp_vec());
        end
      end
      n_chk++;
      if (rst_n_out !== vals[k]) begin
        n_fail++;
        $display("FAIL power_on_spot E%0d got=%b exp=%b", cyc, rst_n_out, vals[k]);
      end
    end
    n_chk++;
    if ({all_ready, busy, rst_cnt} !== {1'b1, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL power_on_done got=%h exp=%h", {all_ready, busy, rst_cnt}, {1'b1, 1'b0, 8'd1});
    end
  endtask

  // Continues from test_power_on (cyc == 31, DONE).
  task automatic test_soft_done();
    while (cyc < 70) begin
      tick(cyc == 39);  // request sampled at edge 40
      n_chk++;
      if ({rst_n_out, all_ready, busy, rst_cnt} !== exp_vec()) begin
        n_fail++;
        $display("FAIL soft_done cyc=%0d got=%h exp=%h", cyc,
                 {rst_n_out, all_ready, busy, rst_cnt}, exp_vec());
      end
`ifdef UVMT_MIO_CLI_ST_RST_SEQ_SW_REQ_EN
      if (cyc == 40 || cyc == 55 || cyc == 56 || cyc == 68) begin
        n_chk++;
        if (rst_n_out !== ((cyc == 56) ? 4'b0001 : (cyc == 68) ? 4'b1111 : 4'b0000)) begin
          n_fail++;
          $display("FAIL soft_done_spot E%0d got=%b", cyc, rst_n_out);
        end
      end
`else
      n_chk++;
      if (rst_n_out !== 4'b1111 || rst_cnt !== 8'd1) begin
        n_fail++;
        $display("FAIL soft_ignored E%0d got=%b/%0d exp=1111/1", cyc, rst_n_out, rst_cnt);
      end
`endif
    end
`ifdef UVMT_MIO_CLI_ST_RST_SEQ_SW_REQ_EN
    n_chk++;
    if (rst_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL soft_done_cnt got=%0d exp=2", rst_cnt);
    end
`endif
  endtask

  task automatic test_soft_mid_release();
    apply_reset(1);
    while (cyc < 55) begin
      tick(cyc == 22);  // request sampled at edge 23, the bit-1 release edge
      n_chk++;
      if ({rst_n_out, all_ready, busy, rst_cnt} !== exp_vec()) begin
        n_fail++;
        $display("FAIL soft_mid_rel cyc=%0d got=%h exp=%h", cyc,
                 {rst_n_out, all_ready, busy, rst_cnt}, exp_vec());
      end
`ifdef UVMT_MIO_CLI_ST_RST_SEQ_SW_REQ_EN
      if (cyc == 23 || cyc == 39 || cyc == 50 || cyc == 51) begin
        n_chk++;
        if ({rst_n_out, rst_cnt} !== ((cyc == 23) ? {4'b0000, 8'd0} :
                                      (cyc == 39) ? {4'b0001, 8'd0} :
                                      (cyc == 50) ? {4'b0111, 8'd0} : {4'b1111, 8'd1})) begin
          n_fail++;
          $display("FAIL soft_mid_rel_spot E%0d got=%b/%0d", cyc, rst_n_out, rst_cnt);
        end
      end
`endif
    end
  endtask

  task automatic test_async_mid_hold();
    apply_reset(1);
    while (cyc < 10) tick(0);
    apply_reset(0);  // low after E10, high again before E12
    while (cyc < 45) begin
      tick(0);
      n_chk++;
      if ({rst_n_out, all_ready, busy, rst_cnt} !== exp_vec()) begin
        n_fail++;
        $display("FAIL async_mid_hold cyc=%0d got=%h exp=%h", cyc,
                 {rst_n_out, all_ready, busy, rst_cnt}, exp_vec());
      end
      if (cyc == 29 || cyc == 30) begin
        n_chk++;
        if (rst_n_out !== ((cyc == 30) ? 4'b0001 : 4'b0000)) begin
          n_fail++;
          $display("FAIL async_mid_hold_spot E%0d got=%b", cyc, rst_n_out);
        end
      end
    end
  endtask

`ifdef UVMT_MIO_CLI_ST_RST_SEQ_SW_REQ_EN
  task automatic test_saturation();
    apply_reset(1);
    while (cyc < 31) tick(0);
    for (int k = 0; k < 260; k++) begin
      tick(1);
      for (int j = 0; j < HOLD + (N-1)*S; j++) begin
        tick(0);
        n_chk++;
        if ({rst_n_out, all_ready, busy, rst_cnt} !== exp_vec()) begin
          n_fail++;
          $display("FAIL saturation k=%0d cyc=%0d got=%h exp=%h", k, cyc,
                   {rst_n_out, all_ready, busy, rst_cnt}, exp_vec());
        end
      end
    end
    n_chk++;
    if (rst_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL saturation_final got=%0d exp=255", rst_cnt);
    end
  endtask
`else
  task automatic test_sw_ignored();
    apply_reset(1);
    while (cyc < 31) tick(0);
    repeat (40) begin
      tick(1);
      n_chk++;
      if ({rst_n_out, all_ready, busy, rst_cnt} !== {4'b1111, 1'b1, 1'b0, 8'd1}) begin
        n_fail++;
        $display("FAIL sw_ignored cyc=%0d got=%h exp=%h", cyc,
                 {rst_n_out, all_ready, busy, rst_cnt}, {4'b1111, 1'b1, 1'b0, 8'd1});
      end
    end
  endtask
`endif

  task automatic test_random();
    apply_reset(1);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        apply_reset(0);
      end else begin
        tick($urandom_range(0, 24) == 0);
        n_chk++;
        if ({rst_n_out, all_ready, busy, rst_cnt} !== exp_vec()) begin
          n_fail++;
          $display("FAIL random cyc=%0d got=%h exp=%h", cyc,
                   {rst_n_out, all_ready, busy, rst_cnt}, exp_vec());
        end
      end
    end
  endtask

  initial begin
    reset_n      = 1'b1;
    sw_reset_req = 1'b0;
    #1;
    test_reset();
    test_power_on();
    test_soft_done();
    test_soft_mid_release();
    test_async_mid_hold();
`ifdef UVMT_MIO_CLI_ST_RST_SEQ_SW_REQ_EN
    test_saturation();
`else
    test_sw_ignored();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
